// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive-side framing for the serial configuration link.
// Tracks frame length between RX_STOP/RX_LOAD, rejects badly sized frames,
// buffers good {addr,data} words in a show-ahead FIFO and keeps sticky
// error flags plus a count of accepted words.
module rx_frame_ctrl #(
  parameter int unsigned FRAME_BITS = 19,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        RX_CLK,
  input  logic        RST,
  input  logic        RX_LOAD,
  input  logic        RX_STOP,
  input  logic [2:0]  P_ADDR,
  input  logic [15:0] P_DATA,
  input  logic        P_ENA,
  input  logic        ERR_CLR,
  output logic [2:0]  OUT_ADDR,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        ERR_LEN,
  output logic        ERR_OVF,
  output logic        ERR_ABORT,
  output logic [7:0]  FRAME_CNT,
  output logic        BUSY
);

  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [4:0]  CNT_MAX  = 5'd31;
  localparam logic [PW:0] PTR_ONE  = (PW + 1)'(1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic        len_ok, len_ok_d, abort_set;

  logic [18:0] mem [FIFO_DEPTH];
  logic [18:0] head;
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push, room;
  logic        len_set, ovf_set;

  // Link state and bit counter registers
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      len_ok_d <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      len_ok_d <= len_ok;
    end
  end

  // Next link state, bit count, length check and abort detection
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    len_ok      = 1'b0;
    abort_set   = 1'b0;
    case (state)
      S_IDLE: begin
        bit_cnt_nxt = '0;
        if (!RX_STOP) begin
          // this cycle is bit 0, so the next one is bit 1
          state_nxt   = S_ACTIVE;
          bit_cnt_nxt = 5'd1;
        end
      end
      S_ACTIVE: begin
        len_ok = RX_LOAD && (bit_cnt == LAST_BIT);
        if (RX_STOP) begin
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
          abort_set   = (bit_cnt != '0);
        end else if (RX_LOAD) begin
          bit_cnt_nxt = '0;
        end else if (bit_cnt != CNT_MAX) begin
          bit_cnt_nxt = bit_cnt + 5'd1;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // FIFO status, handshake and capture decisions
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    pop     = !empty && OUT_READY;
    room    = !full || pop;
    push    = P_ENA && len_ok_d && room;
    len_set = P_ENA && !len_ok_d;
    ovf_set = P_ENA && len_ok_d && !room;
  end

  // Word storage; contents need no reset since OUT_* is masked while empty
  always_ff @(posedge RX_CLK) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {P_ADDR, P_DATA};
  end

  // FIFO pointers, accepted-word count and sticky error flags
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FRAME_CNT <= '0;
      ERR_LEN   <= 1'b0;
      ERR_OVF   <= 1'b0;
      ERR_ABORT <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      ERR_LEN   <= len_set   || (ERR_LEN   && !ERR_CLR);
      ERR_OVF   <= ovf_set   || (ERR_OVF   && !ERR_CLR);
      ERR_ABORT <= abort_set || (ERR_ABORT && !ERR_CLR);
    end
  end

  // Show-ahead output of the head word
  always_comb begin
    head      = mem[rd_ptr[PW-1:0]];
    OUT_VALID = !empty;
    OUT_ADDR  = empty ? '0 : head[18:16];
    OUT_DATA  = empty ? '0 : head[15:0];
    BUSY      = (state == S_ACTIVE);
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: table of single-frame vectors plus
// hand-written overflow, simultaneous push/pop, abort and reset sequences.
module tb_rx_frame_ctrl;

  logic        RX_CLK, RST, RX_LOAD, RX_STOP, P_ENA, ERR_CLR, OUT_READY;
  logic [2:0]  P_ADDR, OUT_ADDR;
  logic [15:0] P_DATA, OUT_DATA;
  logic        OUT_VALID, ERR_LEN, ERR_OVF, ERR_ABORT, BUSY;
  logic [7:0]  FRAME_CNT;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // deserializer model: word presented on P_ENA the cycle after RX_LOAD
  logic        pend = 1'b0;
  logic [2:0]  pa   = '0;
  logic [15:0] pd   = '0;

  rx_frame_ctrl #(.FRAME_BITS(19), .FIFO_DEPTH(4)) dut (
    .RX_CLK(RX_CLK), .RST(RST), .RX_LOAD(RX_LOAD), .RX_STOP(RX_STOP),
    .P_ADDR(P_ADDR), .P_DATA(P_DATA), .P_ENA(P_ENA), .ERR_CLR(ERR_CLR),
    .OUT_ADDR(OUT_ADDR), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ERR_LEN(ERR_LEN), .ERR_OVF(ERR_OVF),
    .ERR_ABORT(ERR_ABORT), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY)
  );

  initial begin
    RX_CLK = 1'b0;
    forever #5 RX_CLK = ~RX_CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one link cycle; outputs are sampled 1 time unit after the edge
  task automatic step(input logic stop, input logic load, input logic [2:0] a, input logic [15:0] d);
    RX_STOP = stop;
    RX_LOAD = load;
    P_ENA   = pend;
    P_ADDR  = pend ? pa : '0;
    P_DATA  = pend ? pd : '0;
    @(posedge RX_CLK);
    #1;
    pend = load;
    pa   = a;
    pd   = d;
  endtask

  task automatic frame(input int unsigned n, input logic [2:0] a, input logic [15:0] d);
    for (int unsigned i = 0; i < n; i++) step(1'b0, (i == n - 1), a, d);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    RX_STOP = 1'b1; RX_LOAD = 1'b0; P_ENA = 1'b0; P_ADDR = '0; P_DATA = '0;
    ERR_CLR = 1'b0; OUT_READY = 1'b0; pend = 1'b0;
    RST = 1'b0;
    @(posedge RX_CLK);
    #1;
    RST = 1'b1;
    @(posedge RX_CLK);
    #1;
  endtask

  typedef struct {
    int unsigned bits;
    logic [2:0]  a;
    logic [15:0] d;
    logic        clr;
    logic        ev;
    logic [2:0]  ea;
    logic [15:0] ed;
    logic [7:0]  ecnt;
    logic        elen;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{19, 3'd5, 16'hA5C3, 1'b0, 1'b1, 3'd5, 16'hA5C3, 8'd1, 1'b0};
    tbl[1] = '{18, 3'd2, 16'h1111, 1'b0, 1'b0, 3'd0, 16'h0000, 8'd1, 1'b1};
    tbl[2] = '{20, 3'd4, 16'h2222, 1'b0, 1'b0, 3'd0, 16'h0000, 8'd1, 1'b1};
    tbl[3] = '{19, 3'd3, 16'h1234, 1'b0, 1'b1, 3'd3, 16'h1234, 8'd2, 1'b1};
    tbl[4] = '{19, 3'd7, 16'hFFFF, 1'b1, 1'b1, 3'd7, 16'hFFFF, 8'd3, 1'b0};
    tbl[5] = '{18, 3'd1, 16'h5555, 1'b1, 1'b0, 3'd0, 16'h0000, 8'd3, 1'b1};

    // reset state, checked while RST is still asserted
    RST = 1'b0; RX_STOP = 1'b1; RX_LOAD = 1'b0; P_ENA = 1'b0;
    P_ADDR = '0; P_DATA = '0; ERR_CLR = 1'b0; OUT_READY = 1'b0;
    #3;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_addr",  OUT_ADDR, 0);
    chk("rst_data",  OUT_DATA, 0);
    chk("rst_cnt",   FRAME_CNT, 0);
    chk("rst_errs",  {ERR_LEN, ERR_OVF, ERR_ABORT}, 0);
    chk("rst_busy",  BUSY, 0);
    @(posedge RX_CLK);
    #1;
    RST = 1'b1;
    idle();

    // table-driven single frames, each followed by a drain cycle
    for (int unsigned v = 0; v < 6; v++) begin
      OUT_READY = 1'b0;
      frame(tbl[v].bits, tbl[v].a, tbl[v].d);
      ERR_CLR = tbl[v].clr;
      idle();
      ERR_CLR = 1'b0;
      chk($sformatf("v%0d_valid", v), OUT_VALID, tbl[v].ev);
      if (tbl[v].ev) begin
        chk($sformatf("v%0d_addr", v), OUT_ADDR, tbl[v].ea);
        chk($sformatf("v%0d_data", v), OUT_DATA, tbl[v].ed);
      end
      chk($sformatf("v%0d_cnt", v), FRAME_CNT, tbl[v].ecnt);
      chk($sformatf("v%0d_errlen", v), ERR_LEN, tbl[v].elen);
      chk($sformatf("v%0d_errovf", v), ERR_OVF, 0);
      chk($sformatf("v%0d_busy", v), BUSY, 0);
      OUT_READY = 1'b1;
      idle();
      OUT_READY = 1'b0;
      chk($sformatf("v%0d_drained", v), OUT_VALID, 0);
    end

    // overflow: five back-to-back good frames with the consumer stalled
    do_reset();
    for (int unsigned k = 0; k < 5; k++) frame(19, 3'(k), 16'h1000 + 16'(k));
    idle();
    chk("ovf_valid", OUT_VALID, 1);
    chk("ovf_cnt",   FRAME_CNT, 4);
    chk("ovf_flag",  ERR_OVF, 1);
    chk("ovf_len",   ERR_LEN, 0);
    idle();
    chk("ovf_hold_addr", OUT_ADDR, 0);
    chk("ovf_hold_data", OUT_DATA, 16'h1000);
    OUT_READY = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      chk($sformatf("ovf_d%0d_valid", k), OUT_VALID, 1);
      chk($sformatf("ovf_d%0d_addr", k), OUT_ADDR, k);
      chk($sformatf("ovf_d%0d_data", k), OUT_DATA, 16'h1000 + 16'(k));
      idle();
    end
    chk("ovf_empty", OUT_VALID, 0);

    // full FIFO with a pop on the P_ENA cycle of the fifth word
    do_reset();
    for (int unsigned k = 0; k < 5; k++) frame(19, 3'(k), 16'h2000 + 16'(k));
    OUT_READY = 1'b1;
    idle();
    chk("fp_ovf",   ERR_OVF, 0);
    chk("fp_cnt",   FRAME_CNT, 5);
    for (int unsigned k = 1; k < 5; k++) begin
      chk($sformatf("fp_d%0d_valid", k), OUT_VALID, 1);
      chk($sformatf("fp_d%0d_addr", k), OUT_ADDR, k);
      chk($sformatf("fp_d%0d_data", k), OUT_DATA, 16'h2000 + 16'(k));
      idle();
    end
    chk("fp_empty", OUT_VALID, 0);

    // abort: RX_STOP rises at bit 10
    do_reset();
    OUT_READY = 1'b1;
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0);
    chk("ab_busy_before", BUSY, 1);
    idle();
    chk("ab_flag",  ERR_ABORT, 1);
    chk("ab_busy",  BUSY, 0);
    chk("ab_valid", OUT_VALID, 0);
    chk("ab_len",   ERR_LEN, 0);
    idle();
    frame(19, 3'd6, 16'hBEEF);
    idle();
    chk("ab_next_valid", OUT_VALID, 1);
    chk("ab_next_addr",  OUT_ADDR, 6);
    chk("ab_next_data",  OUT_DATA, 16'hBEEF);
    chk("ab_next_cnt",   FRAME_CNT, 1);
    chk("ab_sticky",     ERR_ABORT, 1);
    ERR_CLR = 1'b1;
    idle();
    ERR_CLR = 1'b0;
    chk("ab_cleared", ERR_ABORT, 0);

    // reset mid-frame with words queued and an error pending
    do_reset();
    for (int unsigned k = 0; k < 3; k++) frame(19, 3'(k + 1), 16'h3000 + 16'(k));
    frame(18, 3'd0, 16'h0);
    idle();
    chk("mr_valid_pre", OUT_VALID, 1);
    chk("mr_cnt_pre",   FRAME_CNT, 3);
    chk("mr_len_pre",   ERR_LEN, 1);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0);
    RST = 1'b0;
    #2;
    chk("mr_valid", OUT_VALID, 0);
    chk("mr_cnt",   FRAME_CNT, 0);
    chk("mr_errs",  {ERR_LEN, ERR_OVF, ERR_ABORT}, 0);
    chk("mr_busy",  BUSY, 0);
    RX_STOP = 1'b1; RX_LOAD = 1'b0; P_ENA = 1'b0; pend = 1'b0;
    @(posedge RX_CLK);
    #1;
    RST = 1'b1;
    idle();
    frame(19, 3'd1, 16'h0F0F);
    idle();
    chk("mr_next_valid", OUT_VALID, 1);
    chk("mr_next_addr",  OUT_ADDR, 1);
    chk("mr_next_data",  OUT_DATA, 16'h0F0F);
    chk("mr_next_cnt",   FRAME_CNT, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Receive-side controller for the serial configuration link. It sits after the 19-bit deserializer (3-bit address + 16-bit data) and works out the frame boundary from RX_LOAD/RX_STOP. Frames of the wrong length are rejected. Good words are buffered in a small FIFO and handed to the register-file side over a valid/ready handshake, with error and frame-count status.

## Interface
- FRAME_BITS, 19, required serial bits per frame (RX_LOAD cycle inclusive)
- FIFO_DEPTH, 4, word buffer depth (power of two, 2..16)
- RX_CLK  in  1  link clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- RX_LOAD  in  1  link frame-end strobe, high on last bit cycle
- RX_STOP  in  1  link idle/abort; high = no frame in progress
- P_ADDR  in  3  deserializer address, valid when P_ENA high
- P_DATA  in  16  deserializer data, valid when P_ENA high
- P_ENA  in  1  deserializer word strobe (RX_LOAD delayed 1 cycle)
- ERR_CLR  in  1  synchronous clear of sticky error flags
- OUT_ADDR  out  3  head-of-FIFO address
- OUT_DATA  out  16  head-of-FIFO data
- OUT_VALID  out  1  FIFO non-empty
- OUT_READY  in  1  consumer accepts head word when high with OUT_VALID
- ERR_LEN  out  1  sticky: frame of wrong length or load during stop
- ERR_OVF  out  1  sticky: good word dropped, FIFO full
- ERR_ABORT  out  1  sticky: RX_STOP rose mid-frame
- FRAME_CNT  out  8  count of accepted words, wraps 255->0
- BUSY  out  1  link state is ACTIVE

## Operation
- Link FSM, states IDLE, ACTIVE.
  - IDLE: bit counter held at 0. RX_STOP low -> ACTIVE. This cycle is bit 0 and the counter increments.
  - ACTIVE: counter +1 per cycle, saturating at 31.
  - ACTIVE, RX_STOP high with counter != 0 -> IDLE and set ERR_ABORT.
  - ACTIVE, RX_STOP high with counter == 0 (directly after a load) -> IDLE, no error.
- Frame check happens on the RX_LOAD cycle:
  - len_ok = (counter == FRAME_BITS-1) and state ACTIVE.
  - Counter returns to 0 on the next cycle, so a back-to-back frame starts at bit 0.
  - len_ok is registered one cycle, so it lines up with P_ENA.
- RX_LOAD high in IDLE gives len_ok = 0.
- Word capture on the P_ENA cycle:
  - len_ok_d = 0: discard the word, set ERR_LEN.
  - len_ok_d = 1 and FIFO has room: push {P_ADDR, P_DATA}, FRAME_CNT +1.
  - Room means not full, or a pop happens in the same cycle.
  - len_ok_d = 1 and no room: discard the word, set ERR_OVF. FRAME_CNT does not change.
- FIFO is show-ahead.
  - OUT_* always present the head word; OUT_VALID = not empty.
  - Pop happens when OUT_VALID and OUT_READY are both high.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal.
- Sticky errors:
  - Set has priority over ERR_CLR in the same cycle.
  - ERR_CLR alone clears all three flags next cycle.
- Push and pop in the same cycle: occupancy is unchanged and both take effect.

## Timing
- Reset values: all outputs 0, FSM IDLE, FIFO empty, counters 0, OUT_ADDR/OUT_DATA 0.
- Latency: RX_LOAD at cycle N; P_ENA at N+1; push at the N+1 edge; OUT_VALID high at N+2 if the FIFO was empty.
- OUT_* hold steady while OUT_VALID is high and OUT_READY is low.
- Minimum frame spacing is FRAME_BITS cycles. Sustained throughput is one word per FRAME_BITS cycles, with no stall toward the link.
- RST low mid-frame or mid-handshake: immediate clear, FIFO contents lost. The first frame after release needs RX_STOP low from bit 0.

## Test plan
- Clean frame: RX_STOP low, 19 bits addr=3'b101 data=16'hA5C3, RX_LOAD on bit 18, OUT_READY high -> OUT_VALID at N+2 with OUT_ADDR=5, OUT_DATA=A5C3; FRAME_CNT=1; no errors.
- Length error: RX_LOAD on bit 17 (18-bit frame) -> nothing pushed, ERR_LEN=1, FRAME_CNT=0. Next correct 19-bit frame is accepted; ERR_CLR then clears ERR_LEN.
- Overflow: OUT_READY low, 5 back-to-back good frames -> 4 words buffered, 5th dropped, ERR_OVF=1, FRAME_CNT=4. Drain with OUT_READY high -> words come out in order 0..3.
- Full with simultaneous pop: FIFO full, OUT_READY high on the P_ENA cycle -> push accepted, occupancy stays 4, ERR_OVF=0.
- Abort: RX_STOP high at bit 10 -> ERR_ABORT=1, BUSY=0, no push. Next frame after RX_STOP falls is accepted.
- Reset mid-operation: 3 words queued, RST pulsed low -> OUT_VALID=0, FRAME_CNT=0, errors 0; a following frame is accepted normally.
